ysyx_23060180_mem_responder: RTL and testbench

Memory-side responder for the core's single-port memory bus (mem_rd/mem_wr/mem_raddr/mem_rdata/mem_wdata/mem_wbit_en).
- Backs the bus with a word-organised synchronous RAM at BASE_ADDR.
- Returns read data one cycle after mem_rd.
- Lane-shifts store data by the size code carried on mem_wbit_en.
- Flags out-of-range and misaligned accesses.
- Provides a word-wide preload port for the test environment.
- Optionally exposes a memory-mapped serial byte FIFO.

---
 rtl/ysyx_23060180_mem_pkg.sv | 31 +++
 rtl/ysyx_23060180_byte_fifo.sv | 50 +++++
 rtl/ysyx_23060180_mem_responder.sv | 147 ++++++++++++++
 tb/tb_ysyx_23060180_mem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared constants and store-size helpers for the memory responder.
package ysyx_23060180_mem_pkg;

    localparam logic [3:0]  SZ_B = 4'd1;
    localparam logic [3:0]  SZ_H = 4'd2;
    localparam logic [3:0]  SZ_W = 4'd4;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
    localparam logic [31:0] DEF_SERIAL_ADDR = 32'hA000_03F8;

    function automatic logic size_valid(input logic [3:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [3:0] sz, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (sz)
            SZ_B:    m = 4'b0001 << a;
            SZ_H:    m = 4'b0011 << a;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [3:0] sz, input logic [1:0] a);
        return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_23060180_byte_fifo.sv
// Byte FIFO feeding the serial transmit port; DEPTH must be a power of two.
module ysyx_23060180_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn_in,
    input  logic                   i_push,
    input  logic [7:0]             i_data,
    input  logic                   i_pop,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [7:0]             o_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_buf [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_pop;
    logic          w_push;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_buf[r_rp];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wp] <= i_data;
    end

endmodule

// File: rtl/ysyx_23060180_mem_responder.sv
// Memory-bus responder: word RAM, 1-cycle reads, lane-shifted stores, error log.
// Optional serial FIFO enabled by YSYX_23060180_MEM_SERIAL_EN.
module ysyx_23060180_mem_responder
    import ysyx_23060180_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] SERIAL_ADDR = DEF_SERIAL_ADDR,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wbit_en,
    output logic [31:0] mem_rdata,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_wdata,
    output logic        err,
    output logic [31:0] err_addr
`ifdef YSYX_23060180_MEM_SERIAL_EN
    ,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
`endif
);
    localparam int          IW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RANGE_B = 32'(DEPTH_WORDS) << 2;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_err_addr;

    logic [31:0]   w_off;
    logic          w_in_rng;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_a;
    logic          w_mis;
    logic          w_bus_wr;
    logic          w_ram_wr;
    logic [3:0]    w_lanes;
    logic [31:0]   w_wshift;
    logic [31:0]   w_ioff;
    logic          w_init_ok;
    logic [IW-1:0] w_iidx;
    logic          w_is_ser;
    logic          w_ser_err;
    logic [31:0]   w_ser_rdata;
    logic          w_rd_err;
    logic          w_wr_err;

    // Subtracting the base lets one unsigned compare cover both range limits.
    assign w_off     = mem_raddr - BASE_ADDR;
    assign w_in_rng  = (w_off < RANGE_B);
    assign w_idx     = w_off[IW+1:2];
    assign w_a       = mem_raddr[1:0];
    assign w_mis     = misaligned(mem_wbit_en, w_a);
    assign w_lanes   = lane_mask(mem_wbit_en, w_a);
    assign w_wshift  = mem_wdata << {w_a, 3'b000};

    assign w_ioff    = init_addr - BASE_ADDR;
    assign w_init_ok = init_we && (w_ioff < RANGE_B);
    assign w_iidx    = w_ioff[IW+1:2];

    // A preload in the same cycle silently swallows any bus write.
    assign w_bus_wr  = mem_wr && size_valid(mem_wbit_en) && !init_we;
    assign w_ram_wr  = w_bus_wr && !w_is_ser && w_in_rng && !w_mis;
    assign w_rd_err  = mem_rd && !w_in_rng && !w_is_ser;
    assign w_wr_err  = (w_bus_wr && !w_is_ser && (!w_in_rng || w_mis)) || w_ser_err;

`ifdef YSYX_23060180_MEM_SERIAL_EN
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                        w_push;
    logic                        w_unused;

    assign w_is_ser    = (mem_raddr == SERIAL_ADDR);
    assign w_push      = w_bus_wr && w_is_ser;
    assign w_ser_err   = w_push && w_fifo_full && !tx_ready;
    assign w_ser_rdata = 32'(w_fifo_count);
    assign tx_valid    = !w_fifo_empty;
    assign w_unused    = ^{init_addr[1:0], w_off[1:0], w_ioff[1:0]};

    ysyx_23060180_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn_in (rstn_in),
        .i_push  (w_push),
        .i_data  (mem_wdata[7:0]),
        .i_pop   (tx_ready),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_data  (tx_data)
    );
`else
    logic w_unused;

    assign w_is_ser    = 1'b0;
    assign w_ser_err   = 1'b0;
    assign w_ser_rdata = 32'h0;
    assign w_unused    = ^{SERIAL_ADDR, 32'(FIFO_DEPTH), init_addr[1:0], w_off[1:0], w_ioff[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (w_init_ok) begin
            r_mem[w_iidx] <= init_wdata;
        end else if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lanes[i]) r_mem[w_idx][8*i +: 8] <= w_wshift[8*i +: 8];
            end
        end
    end

    // Read samples the pre-write word, giving read-first on same-word collisions.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            r_rdata <= 32'h0;
        end else if (mem_rd) begin
            if (w_is_ser)      r_rdata <= w_ser_rdata;
            else if (w_in_rng) r_rdata <= r_mem[w_idx] >> {w_a, 3'b000};
            else               r_rdata <= 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'h0;
        end else if (!r_err && (w_rd_err || w_wr_err)) begin
            r_err      <= 1'b1;
            r_err_addr <= mem_raddr;
        end
    end

    assign mem_rdata = r_rdata;
    assign err       = r_err;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_ysyx_23060180_mem_responder.sv
// Directed and randomized bench for ysyx_23060180_mem_responder with a byte-level reference model.
module tb_ysyx_23060180_mem_responder;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] RANGE  = 32'h0001_0000;
    localparam logic [31:0] SERIAL = 32'hA000_03F8;

    logic        clk = 1'b0;
    logic        rstn_in;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_raddr, mem_wdata;
    logic [3:0]  mem_wbit_en;
    logic [31:0] mem_rdata;
    logic        init_we;
    logic [31:0] init_addr, init_wdata;
    logic        err;
    logic [31:0] err_addr;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl [65536];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_err_addr;

    always #5 clk = ~clk;

    ysyx_23060180_mem_responder dut (
        .clk         (clk),
        .rstn_in     (rstn_in),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_raddr   (mem_raddr),
        .mem_wdata   (mem_wdata),
        .mem_wbit_en (mem_wbit_en),
        .mem_rdata   (mem_rdata),
        .init_we     (init_we),
        .init_addr   (init_addr),
        .init_wdata  (init_wdata),
        .err         (err),
        .err_addr    (err_addr)
`ifdef YSYX_23060180_MEM_SERIAL_EN
        ,
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready)
`endif
    );

`ifndef YSYX_23060180_MEM_SERIAL_EN
    assign tx_valid = 1'b0;
    assign tx_data  = 8'h0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sz);
        mem_rd = rd; mem_wr = wr; mem_raddr = a; mem_wdata = d; mem_wbit_en = sz;
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0; mem_wbit_en = 4'd0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        init_we = 1'b1; init_addr = a; init_wdata = d;
        tick();
        init_we = 1'b0;
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a - BASE) < RANGE;
    endfunction

    // Read: the bytes from the address up to the end of its word, low byte first.
    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        logic [31:0] r;
        int off;
        r = 32'h0;
        off = int'(a - BASE);
        for (int k = 0; k < 4 - int'(a[1:0]); k++) r[8*k +: 8] = mdl[off + k];
        return r;
    endfunction

    function automatic int size_bytes(input logic [3:0] sz);
        return (sz == 4'd1) ? 1 : (sz == 4'd2) ? 2 : (sz == 4'd4) ? 4 : 0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_raddr = 32'h0; mem_wdata = 32'h0;
        mem_wbit_en = 4'd0; init_we = 1'b0; init_addr = 32'h0; init_wdata = 32'h0; tx_ready = 1'b0;
        tick(); tick();
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_err", {31'h0, err}, 32'h0);
        chk("reset_err_addr", err_addr, 32'h0);
        rstn_in = 1'b1;

        preload(32'h8000_0000, 32'h1122_3344);
        bus(1, 0, 32'h8000_0002, 0, 0);
        chk("rd_off2", mem_rdata, 32'h0000_1122);
        bus(1, 0, 32'h8000_0003, 0, 0);
        chk("rd_off3", mem_rdata, 32'h0000_0011);

        bus(0, 1, 32'h8000_0001, 32'h0000_00AB, 4'd1);
        bus(1, 0, 32'h8000_0000, 0, 0);
        chk("sb_lane1", mem_rdata, 32'h1122_AB44);
        bus(0, 1, 32'h8000_0002, 32'h0000_BEEF, 4'd2);
        bus(1, 0, 32'h8000_0000, 0, 0);
        chk("sh_lane2", mem_rdata, 32'hBEEF_AB44);

        bus(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd3);
        bus(1, 0, 32'h8000_0000, 0, 0);
        chk("bad_size_noop", mem_rdata, 32'hBEEF_AB44);
        chk("bad_size_no_err", {31'h0, err}, 32'h0);
        mem_raddr = 32'h8000_0003;
        tick();
        chk("rdata_hold", mem_rdata, 32'hBEEF_AB44);

        preload(32'h8000_0004, 32'h0102_0304);
        bus(0, 1, 32'h8000_0006, 32'hCAFE_F00D, 4'd4);
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_err_addr", err_addr, 32'h8000_0006);
        bus(1, 0, 32'h8000_0004, 0, 0);
        chk("mis_unchanged", mem_rdata, 32'h0102_0304);
        bus(1, 0, 32'h7000_0000, 0, 0);
        chk("oor_rdata", mem_rdata, 32'h0);
        chk("err_addr_sticky", err_addr, 32'h8000_0006);

        preload(32'h8000_FFFC, 32'hDEAD_BEEF);
        bus(1, 0, 32'h8000_FFFF, 0, 0);
        chk("last_byte", mem_rdata, 32'h0000_00DE);
        bus(1, 0, 32'h8001_0000, 0, 0);
        chk("just_above", mem_rdata, 32'h0);

        preload(32'h8000_0010, 32'h5);
        bus(1, 1, 32'h8000_0010, 32'h9, 4'd4);
        chk("rd_first", mem_rdata, 32'h5);
        bus(1, 0, 32'h8000_0010, 0, 0);
        chk("wr_landed", mem_rdata, 32'h9);
        init_we = 1'b1; init_addr = 32'h8000_0010; init_wdata = 32'h77;
        bus(0, 1, 32'h8000_0010, 32'h99, 4'd4);
        init_we = 1'b0;
        bus(1, 0, 32'h8000_0010, 0, 0);
        chk("init_wins", mem_rdata, 32'h77);

        bus(1, 0, 32'h8000_0000, 0, 0);
        mem_rd = 1'b1; mem_raddr = 32'h8000_0004; rstn_in = 1'b0;
        tick();
        mem_rd = 1'b0;
        chk("rst_abort_rdata", mem_rdata, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        rstn_in = 1'b1;
        bus(1, 0, 32'h8000_0000, 0, 0);
        chk("ram_kept", mem_rdata, 32'hBEEF_AB44);

        // Randomized phase over the first 16 words plus addresses just outside the range.
        rstn_in = 1'b0; tick(); rstn_in = 1'b1;
        exp_rdata = 32'h0; exp_err = 1'b0; exp_err_addr = 32'h0;
        for (int w = 0; w < 16; w++) begin
            logic [31:0] v;
            v = $urandom;
            preload(BASE + 32'(4*w), v);
            for (int k = 0; k < 4; k++) mdl[4*w + k] = v[8*k +: 8];
        end
        for (int n = 0; n < 300; n++) begin
            logic        rd, wr, iw, ev_err;
            logic [31:0] a, d, ia, id;
            logic [3:0]  sz;
            int          pick;
            rd = 1'($urandom); wr = 1'($urandom); iw = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0)
                a = ($urandom_range(0, 1) == 0) ? (BASE - 32'($urandom_range(1, 4)))
                                                : (BASE + RANGE + 32'($urandom_range(0, 3)));
            else
                a = BASE + 32'($urandom_range(0, 63));
            d = $urandom;
            pick = $urandom_range(0, 5);
            sz = (pick == 0) ? 4'd1 : (pick == 1) ? 4'd2 : (pick <= 3) ? 4'd4 : (pick == 4) ? 4'd3 : 4'd0;
            ia = BASE + 32'($urandom_range(0, 63));
            id = $urandom;

            ev_err = 1'b0;
            if (rd) begin
                exp_rdata = in_rng(a) ? mdl_read(a) : 32'h0;
                if (!in_rng(a)) ev_err = 1'b1;
            end
            if (wr && size_bytes(sz) != 0 && !iw) begin
                if (!in_rng(a) || (sz == 4'd2 && a[0]) || (sz == 4'd4 && a[1:0] != 2'b00))
                    ev_err = 1'b1;
                else
                    for (int k = 0; k < size_bytes(sz); k++) mdl[int'(a - BASE) + k] = d[8*k +: 8];
            end
            if (iw)
                for (int k = 0; k < 4; k++) mdl[(int'(ia - BASE) & ~3) + k] = id[8*k +: 8];
            if (ev_err && !exp_err) begin
                exp_err = 1'b1;
                exp_err_addr = a;
            end

            init_we = iw; init_addr = ia; init_wdata = id;
            bus(rd, wr, a, d, sz);
            init_we = 1'b0;
            chk("rnd_rdata", mem_rdata, exp_rdata);
            chk("rnd_err", {31'h0, err}, {31'h0, exp_err});
            chk("rnd_err_addr", err_addr, exp_err_addr);
        end

`ifdef YSYX_23060180_MEM_SERIAL_EN
        rstn_in = 1'b0; tick(); rstn_in = 1'b1;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus(0, 1, SERIAL, 32'hFF00 | 32'(i + 1), 4'd1);
        chk("ser_no_err_8", {31'h0, err}, 32'h0);
        chk("ser_valid", {31'h0, tx_valid}, 32'h1);
        chk("ser_head", {24'h0, tx_data}, 32'h1);
        bus(0, 1, SERIAL, 32'h9, 4'd1);
        chk("ser_full_err", {31'h0, err}, 32'h1);
        chk("ser_full_err_addr", err_addr, SERIAL);
        bus(1, 0, SERIAL, 0, 0);
        chk("ser_count", mem_rdata, 32'h8);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ser_drain_valid", {31'h0, tx_valid}, 32'h1);
            chk("ser_drain_data", {24'h0, tx_data}, 32'(i + 1));
            tick();
        end
        chk("ser_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
